// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART for the MEM stage.
// DATA register at 0xBFD003F8 and STATUS register at 0xBFD003FC.
// Contains TX/RX byte FIFOs, a TX serializer and an RX deserializer.

// Byte FIFO with an extra pointer bit that tells full apart from empty.
// Push and pop are gated internally by full/empty as seen before the edge.
module uart_mmio_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Status flags and the gated push/pop strobes.
  always_comb begin
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_o  = (wr_ptr_q == rd_ptr_q);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; wrap-around is modular in AW+1 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module uart_mmio #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_dataadr,
  input  logic [31:0] MEM_wdata,
  input  logic        MEM_we,
  input  logic        MEM_oe,
  output logic [31:0] MEM_rdata,
  output logic        uart_sel,
  output logic        txd,
  input  logic        rxd
);
  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [31:0] ADDR_DATA = 32'hBFD003F8;
  localparam logic [31:0] ADDR_STAT = 32'hBFD003FC;

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  // Bus decode
  logic is_data, is_stat, bus_wr, bus_rd, stat_rd;
  logic tx_push, rx_pop;
  logic unused_wdata;

  // FIFO interface
  logic [7:0] tx_head, rx_head;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_pop, rx_push;

  // TX state
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;

  // RX state
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic          ovr_q, ovr_d, ovr_set;

  assign unused_wdata = ^MEM_wdata[31:8];
  assign rxs          = sync_q[1];

  // Address decode, access qualification and combinational read data.
  always_comb begin
    is_data   = (MEM_dataadr == ADDR_DATA);
    is_stat   = (MEM_dataadr == ADDR_STAT);
    uart_sel  = is_data || is_stat;
    bus_wr    = uart_sel && MEM_we;
    // A cycle with both strobes high is a write only.
    bus_rd    = uart_sel && MEM_oe && !MEM_we;
    stat_rd   = bus_rd && is_stat;
    tx_push   = bus_wr && is_data;
    rx_pop    = bus_rd && is_data;
    MEM_rdata = '0;
    if (bus_rd && is_data && !rx_empty) begin
      MEM_rdata = {24'b0, rx_head};
    end else if (stat_rd) begin
      MEM_rdata = {29'b0, ovr_q, !rx_empty, !tx_full};
    end
  end

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push_i (tx_push),
    .wdata_i(MEM_wdata[7:0]),
    .pop_i  (tx_pop),
    .rdata_o(tx_head),
    .full_o (tx_full),
    .empty_o(tx_empty)
  );

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push_i (rx_push),
    .wdata_i(rx_sh_q),
    .pop_i  (rx_pop),
    .rdata_o(rx_head),
    .full_o (rx_full),
    .empty_o(rx_empty)
  );

  // TX next-state: load from FIFO, then start, 8 data bits LSB first, stop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      T_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = T_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      T_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // Line level decoded from TX state so reset forces idle-high at once.
  always_comb begin
    txd = 1'b1;
    if (tx_state_q == T_START)     txd = 1'b0;
    else if (tx_state_q == T_DATA) txd = tx_sh_q[0];
  end

  // TX state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  // RX next-state: mid-start glitch check, 8 mid-bit samples, stop check.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!rxs) begin
          rx_cnt_d   = '0;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxs ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxs, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = R_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          if (rxs) begin
            if (!rx_full) rx_push = 1'b1;
            else          ovr_set = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Overrun: a STATUS read clears it, a same-cycle overrun wins.
  always_comb begin
    ovr_d = ovr_q;
    if (stat_rd) ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
  end

  // RX synchronizer, RX state registers and overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 2'b11;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rxd};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      ovr_q      <= ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed testbench for uart_mmio with CLK_FREQ=160, BAUD=10 (16 clocks/bit).
module tb_uart_mmio;
  localparam int DIV = 16;
  localparam logic [31:0] A_DATA = 32'hBFD003F8;
  localparam logic [31:0] A_STAT = 32'hBFD003FC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        oe = 1'b0;
  logic [31:0] rdata;
  logic        sel;
  logic        txd;
  logic        rxd = 1'b1;

  int checks = 0;
  int failures = 0;
  logic [7:0] txq [$];
  logic [7:0] mon_b;

  uart_mmio #(.CLK_FREQ(160), .BAUD(10), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_dataadr(addr),
    .MEM_wdata  (wdata),
    .MEM_we     (we),
    .MEM_oe     (oe),
    .MEM_rdata  (rdata),
    .uart_sel   (sel),
    .txd        (txd),
    .rxd        (rxd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0; addr = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; oe = 1'b1;
    #1 d = rdata;
    @(posedge clk);
    #1 oe = 1'b0; addr = '0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stopb;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Reference serial receiver on txd: samples mid-bit, collects bytes.
  initial begin
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          mon_b[i] = txd;
        end
        repeat (DIV) @(negedge clk);
        txq.push_back(mon_b);
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  pat;
    int          lows;

    // Reset
    repeat (3) @(negedge clk);
    chk("txd_in_reset", {31'b0, txd}, 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("txd_after_reset", {31'b0, txd}, 32'h1);
    rd(A_STAT, d);
    chk("status_after_reset", d, 32'h1);

    // Decode
    @(negedge clk);
    addr = A_STAT; #1;
    chk("sel_status", {31'b0, sel}, 32'h1);
    addr = 32'hBFD003F4; oe = 1'b1; #1;
    chk("sel_other", {31'b0, sel}, 32'h0);
    chk("rdata_other", rdata, 32'h0);
    oe = 1'b0; addr = '0;

    // Single frame 0xA5, exact timing
    txq.delete();
    wr(A_DATA, 32'h123456A5);
    pat = 8'hA5;
    for (int i = 0; i < 161; i++) begin
      logic expb;
      @(posedge clk);
      #1;
      if (i < 16)       expb = 1'b0;
      else if (i < 144) expb = pat[(i - 16) / 16];
      else              expb = 1'b1;
      chk($sformatf("txd_a5_clk%0d", i), {31'b0, txd}, {31'b0, expb});
    end
    chk("mon_a5_count", txq.size(), 32'd1);
    chk("mon_a5_byte", {24'b0, txq[0]}, 32'hA5);

    // 17 back-to-back writes fill FIFO; 18th dropped
    txq.delete();
    for (int i = 0; i < 17; i++) wr(A_DATA, i);
    rd(A_STAT, d);
    chk("status_tx_full", d, 32'h0);
    wr(A_DATA, 32'hFF);
    rd(A_STAT, d);
    chk("status_tx_full_after_drop", d, 32'h0);
    for (int t = 0; t < 3400 && txq.size() < 17; t++) @(negedge clk);
    repeat (300) @(negedge clk);
    chk("tx_stream_count", txq.size(), 32'd17);
    for (int i = 0; i < 17; i++)
      chk($sformatf("tx_stream_byte%0d", i), {24'b0, txq[i]}, i);

    // Single RX frame 0x3C
    send_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    rd(A_STAT, d);
    chk("status_rx_avail", d, 32'h3);
    rd(A_DATA, d);
    chk("rx_data_3c", d, 32'h3C);
    rd(A_STAT, d);
    chk("status_rx_drained", d, 32'h1);

    // 17 frames without reading: overrun
    for (int i = 0; i < 17; i++) send_rx(8'(8'h40 + i), 1'b1);
    repeat (4) @(negedge clk);
    rd(A_STAT, d);
    chk("status_overrun", d, 32'h7);
    rd(A_STAT, d);
    chk("status_overrun_cleared", d, 32'h3);
    for (int i = 0; i < 16; i++) begin
      rd(A_DATA, d);
      chk($sformatf("rx_fifo_byte%0d", i), d, 32'(8'h40 + i));
    end
    rd(A_DATA, d);
    chk("rx_empty_read", d, 32'h0);
    rd(A_STAT, d);
    chk("status_rx_empty", d, 32'h1);

    // Short glitch on rxd
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    rd(A_STAT, d);
    chk("status_after_glitch", d, 32'h1);

    // Framing error
    send_rx(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    rd(A_STAT, d);
    chk("status_after_framing_err", d, 32'h1);

    // Both strobes: write only, no RX pop
    send_rx(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    @(negedge clk);
    addr = A_DATA; wdata = 32'h11; we = 1'b1; oe = 1'b1; #1;
    chk("rdata_we_and_oe", rdata, 32'h0);
    @(posedge clk);
    #1 we = 1'b0; oe = 1'b0; addr = '0;
    rd(A_DATA, d);
    chk("rx_not_popped_by_write", d, 32'h5A);

    // Reset mid TX frame
    wr(A_DATA, 32'h22);
    repeat (5) @(negedge clk);
    chk("txd_start_before_reset", {31'b0, txd}, 32'h0);
    rst = 1'b0;
    #1;
    chk("txd_async_reset", {31'b0, txd}, 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("txd_idle_after_reset", lows, 32'd0);
    rd(A_STAT, d);
    chk("status_after_mid_reset", d, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
